rc4_xor_stream: RTL and testbench

- Downstream consumer of the RC4 keystream generator.
- Buffers keystream bytes (ckey) in a small FIFO and XORs them one-for-one with a plaintext byte stream under valid/ready handshakes.
- Emits ciphertext bytes and counts bytes against a programmed message length.
- Signals completion so the top level can start the next message. Because RC4 encryption and decryption are the same operation, the block serves both directions.

---
 rtl/rc4_xor_stream.sv | 131 +++++++++++++
 tb/tb_rc4_xor_stream.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_xor_stream.sv
// rc4_xor_stream
//   Combines an RC4 keystream with a plaintext byte stream. Keystream bytes
//   are buffered in a small FIFO and XORed one-for-one with plaintext bytes
//   under valid/ready handshakes. Encryption and decryption are the same
//   operation, so the block serves both directions.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   RUN   | combining plaintext with keystream until msg_len bytes done
//   FLUSH | last ciphertext byte waiting for the sink
//   DONE  | message complete; start launches the next message
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start, msg_len           begin a message of msg_len bytes (IDLE/DONE only)
//   ks_valid/ks_data/ks_ready keystream input into the FIFO
//   pt_valid/pt_data/pt_ready plaintext input
//   ct_valid/ct_data/ct_ready ciphertext output (registered)
//   byte_cnt                 bytes combined in the current message
//   busy, done               RUN/FLUSH, and DONE status
module rc4_xor_stream #(
  parameter int KS_DEPTH = 8,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             pt_valid,
  input  logic [7:0]       pt_data,
  output logic             pt_ready,
  output logic             ct_valid,
  output logic [7:0]       ct_data,
  input  logic             ct_ready,
  output logic [LEN_W-1:0] byte_cnt,
  output logic             busy,
  output logic             done
);

  localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(KS_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state;
  logic [7:0]       ks_mem [KS_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      ks_count;
  logic [LEN_W-1:0] len_q;

  logic ks_push;
  logic slot_ok;
  logic fire;
  logic last_byte;

  // ks_ready comes from the registered count only, so a pop in the same
  // cycle does not open a slot until the next cycle.
  assign ks_ready  = (ks_count != CNT_FULL);
  assign ks_push   = ks_valid && ks_ready;
  assign slot_ok   = (state == S_RUN) && (ks_count != '0) && (!ct_valid || ct_ready);
  assign pt_ready  = slot_ok;
  assign fire      = slot_ok && pt_valid;
  assign last_byte = ((byte_cnt + LEN_W'(1)) == len_q);
  assign busy      = (state == S_RUN) || (state == S_FLUSH);
  assign done      = (state == S_DONE);

  // Storage has no reset; validity is tracked entirely by ks_count.
  always_ff @(posedge clk) begin
    if (ks_push) ks_mem[wr_ptr] <= ks_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ks_count <= '0;
      ct_valid <= 1'b0;
      ct_data  <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
    end else begin
      if (ks_push) wr_ptr <= wr_ptr + PW'(1);
      if (fire)    rd_ptr <= rd_ptr + PW'(1);

      case ({ks_push, fire})
        2'b10:   ks_count <= ks_count + (PW+1)'(1);
        2'b01:   ks_count <= ks_count - (PW+1)'(1);
        default: ks_count <= ks_count;
      endcase

      if (fire) begin
        ct_data  <= pt_data ^ ks_mem[rd_ptr];
        ct_valid <= 1'b1;
      end else if (ct_valid && ct_ready) begin
        ct_valid <= 1'b0;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q    <= msg_len;
            byte_cnt <= '0;
            state    <= (msg_len != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (fire) begin
            byte_cnt <= byte_cnt + LEN_W'(1);
            if (last_byte) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (ct_valid && ct_ready) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// tb_rc4_xor_stream
//   Directed bench for rc4_xor_stream: reset state, basic combine, keystream
//   starvation, ciphertext backpressure, FIFO full, message boundaries,
//   zero-length messages and reset in the middle of a message.
module tb_rc4_xor_stream;
  localparam int KS_DEPTH = 8;
  localparam int LEN_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             ks_valid;
  logic [7:0]       ks_data;
  logic             ks_ready;
  logic             pt_valid;
  logic [7:0]       pt_data;
  logic             pt_ready;
  logic             ct_valid;
  logic [7:0]       ct_data;
  logic             ct_ready;
  logic [LEN_W-1:0] byte_cnt;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  int accepted;
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  rc4_xor_stream #(.KS_DEPTH(KS_DEPTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .msg_len  (msg_len),
    .ks_valid (ks_valid),
    .ks_data  (ks_data),
    .ks_ready (ks_ready),
    .pt_valid (pt_valid),
    .pt_data  (pt_data),
    .pt_ready (pt_ready),
    .ct_valid (ct_valid),
    .ct_data  (ct_data),
    .ct_ready (ct_ready),
    .byte_cnt (byte_cnt),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ks(input logic [7:0] b);
    chk("ks_ready_before_push", 32'(ks_ready), 32'd1);
    ks_valid = 1'b1;
    ks_data  = b;
    tick();
    ks_valid = 1'b0;
  endtask

  task automatic start_msg(input logic [LEN_W-1:0] len);
    start   = 1'b1;
    msg_len = len;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; msg_len = '0;
    ks_valid = 1'b0; ks_data = '0;
    pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ks_ready", 32'(ks_ready), 32'd1);
    chk("rst_pt_ready", 32'(pt_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ct_valid", 32'(ct_valid), 32'd0);
    chk("rst_ct_data",  32'(ct_data),  32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic three-byte message
    push_ks(8'h12); push_ks(8'h34); push_ks(8'h56);
    start_msg(16'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    ct_ready = 1'b1; pt_valid = 1'b1; pt_data = 8'h41;
    #1 chk("t1_pt_ready", 32'(pt_ready), 32'd1);
    tick();
    chk("t1_ct0_valid", 32'(ct_valid), 32'd1);
    chk("t1_ct0", 32'(ct_data), 32'h53);
    pt_data = 8'h42;
    tick();
    chk("t1_ct1", 32'(ct_data), 32'h76);
    pt_data = 8'h43;
    tick();
    chk("t1_ct2", 32'(ct_data), 32'h15);
    chk("t1_cnt3", 32'(byte_cnt), 32'd3);
    pt_data = 8'h44;
    #1 chk("t1_flush_pt_ready", 32'(pt_ready), 32'd0);
    chk("t1_flush_busy", 32'(busy), 32'd1);
    tick();
    pt_valid = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_ct_valid", 32'(ct_valid), 32'd0);
    chk("t1_done_cnt", 32'(byte_cnt), 32'd3);

    // Keystream starvation
    start_msg(16'd1);
    pt_valid = 1'b1; pt_data = 8'hA5;
    #1 chk("t2_starved_pt_ready0", 32'(pt_ready), 32'd0);
    tick();
    chk("t2_starved_pt_ready1", 32'(pt_ready), 32'd0);
    chk("t2_starved_ct_valid", 32'(ct_valid), 32'd0);
    ks_valid = 1'b1; ks_data = 8'hFF;
    #1 chk("t2_no_bypass", 32'(pt_ready), 32'd0);
    tick();
    ks_valid = 1'b0;
    chk("t2_pt_ready_after_push", 32'(pt_ready), 32'd1);
    tick();
    pt_valid = 1'b0;
    chk("t2_ct", 32'(ct_data), 32'h5A);
    chk("t2_ct_valid", 32'(ct_valid), 32'd1);
    tick();
    chk("t2_done", 32'(done), 32'd1);

    // Ciphertext backpressure
    push_ks(8'h01); push_ks(8'h02); push_ks(8'h03); push_ks(8'h04);
    start_msg(16'd4);
    ct_ready = 1'b1; pt_valid = 1'b1; pt_data = 8'h10;
    tick();
    ct_ready = 1'b0; pt_data = 8'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_stall%0d_ct_valid", i), 32'(ct_valid), 32'd1);
      chk($sformatf("t3_stall%0d_ct", i), 32'(ct_data), 32'h11);
      chk($sformatf("t3_stall%0d_pt_ready", i), 32'(pt_ready), 32'd0);
      chk($sformatf("t3_stall%0d_cnt", i), 32'(byte_cnt), 32'd1);
      tick();
    end
    ct_ready = 1'b1;
    #1 chk("t3_resume_pt_ready", 32'(pt_ready), 32'd1);
    tick();
    chk("t3_ct1", 32'(ct_data), 32'h22);
    pt_data = 8'h30;
    tick();
    chk("t3_ct2", 32'(ct_data), 32'h33);
    pt_data = 8'h40;
    tick();
    chk("t3_ct3", 32'(ct_data), 32'h44);
    chk("t3_cnt", 32'(byte_cnt), 32'd4);
    pt_valid = 1'b0;
    tick();
    chk("t3_done", 32'(done), 32'd1);

    // FIFO full
    for (int i = 0; i < 8; i++) begin
      exp_b = 8'hA0 + 8'(i);
      push_ks(exp_b);
    end
    chk("t4_full_ks_ready", 32'(ks_ready), 32'd0);
    ks_valid = 1'b1; ks_data = 8'hA8;
    tick();
    chk("t4_held_ks_ready", 32'(ks_ready), 32'd0);
    start_msg(16'd1);
    ct_ready = 1'b1; pt_valid = 1'b1; pt_data = 8'h00;
    #1;
    chk("t4_pop_cycle_ks_ready", 32'(ks_ready), 32'd0);
    chk("t4_pop_cycle_pt_ready", 32'(pt_ready), 32'd1);
    tick();
    pt_valid = 1'b0;
    chk("t4_after_pop_ks_ready", 32'(ks_ready), 32'd1);
    chk("t4_ct", 32'(ct_data), 32'hA0);
    tick();
    ks_valid = 1'b0;
    chk("t4_refull_ks_ready", 32'(ks_ready), 32'd0);
    chk("t4_done", 32'(done), 32'd1);

    // Message boundary: FIFO holds A1..A8
    start_msg(16'd4);
    pt_valid = 1'b1; pt_data = 8'h00; ct_ready = 1'b1;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      if (pt_ready) accepted++;
      tick();
      exp_b = 8'hA1 + 8'(i);
      chk($sformatf("t5a_ct%0d", i), 32'(ct_data), 32'(exp_b));
      chk($sformatf("t5a_cnt%0d", i), 32'(byte_cnt), 32'(i + 1));
    end
    if (pt_ready) accepted++;
    chk("t5a_flush_pt_ready", 32'(pt_ready), 32'd0);
    tick();
    chk("t5a_accepted", 32'(accepted), 32'd4);
    chk("t5a_done", 32'(done), 32'd1);
    chk("t5a_cnt_hold", 32'(byte_cnt), 32'd4);
    start_msg(16'd2);
    accepted = 0;
    for (int i = 0; i < 2; i++) begin
      if (pt_ready) accepted++;
      tick();
      exp_b = 8'hA5 + 8'(i);
      chk($sformatf("t5b_ct%0d", i), 32'(ct_data), 32'(exp_b));
    end
    if (pt_ready) accepted++;
    tick();
    pt_valid = 1'b0;
    chk("t5b_accepted", 32'(accepted), 32'd2);
    chk("t5b_cnt", 32'(byte_cnt), 32'd2);
    chk("t5b_done", 32'(done), 32'd1);

    // Reset mid-RUN with pending ciphertext (FIFO holds A7, A8, 77)
    push_ks(8'h77);
    start_msg(16'd5);
    pt_valid = 1'b1; pt_data = 8'h00; ct_ready = 1'b0;
    tick();
    chk("t6_pre_rst_ct_valid", 32'(ct_valid), 32'd1);
    chk("t6_pre_rst_ct", 32'(ct_data), 32'hA7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pt_valid = 1'b0;
    chk("t6_rst_ct_valid", 32'(ct_valid), 32'd0);
    chk("t6_rst_ks_ready", 32'(ks_ready), 32'd1);
    chk("t6_rst_cnt", 32'(byte_cnt), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);

    // Zero-length message from IDLE
    pt_valid = 1'b1; ct_ready = 1'b1;
    start_msg(16'd0);
    chk("t6_zero_done", 32'(done), 32'd1);
    chk("t6_zero_busy", 32'(busy), 32'd0);
    chk("t6_zero_pt_ready", 32'(pt_ready), 32'd0);

    // Buffered keystream was discarded by the reset
    start_msg(16'd1);
    chk("t6_post_rst_busy", 32'(busy), 32'd1);
    chk("t6_post_rst_fifo_empty", 32'(pt_ready), 32'd0);
    tick();
    chk("t6_post_rst_no_ct", 32'(ct_valid), 32'd0);
    pt_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
